// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit, ALU and datapath:
// ALU commands, opcode/funct values, state numbering and mux select codes.
package mc_control_fsm_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_cmd_e;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEMADDR   = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WRITE = 4'd4,
        ST_WB_MEM    = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_WB_R      = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_WB_I      = 4'd9,
        ST_BRANCH_EQ = 4'd10,
        ST_BRANCH_NE = 4'd11,
        ST_JUMP      = 4'd12,
        ST_JAL       = 4'd13,
        ST_JR        = 4'd14,
        ST_ERROR     = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG_B   = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG_A  = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    typedef struct packed {
        alu_cmd_e   alu_command;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // Only the three supported R-type arithmetic functs reach EXEC_R.
    function automatic alu_cmd_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bus: instruction fields and zero flag in, datapath controls,
// sticky illegal flag and debug state out.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_command;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output alu_command, alu_src_a, alu_src_b, pc_we, pc_src, ir_we,
               mem_we, reg_we, reg_dst, mem_to_reg, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_command, alu_src_a, alu_src_b, pc_we, pc_src, ir_we,
               mem_we, reg_we, reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decoder; the only inputs besides state are
// the instruction fields for ALU command selection and zero for branches.
module mc_output_decode
    import mc_control_fsm_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o             = '0;
        ctrl_o.alu_command = ALU_ADD;
        ctrl_o.alu_src_b   = SRCB_REG_B;
        ctrl_o.pc_src      = PC_ALU;
        ctrl_o.reg_dst     = DST_RT;
        ctrl_o.mem_to_reg  = M2R_ALUOUT;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.ir_we     = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.pc_we     = 1'b1;
            end
            ST_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ST_MEMADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ST_MEM_WRITE: ctrl_o.mem_we = 1'b1;
            ST_WB_MEM: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_command = funct_to_alu(funct_i);
            end
            ST_WB_R: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = DST_RD;
            end
            ST_EXEC_I: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = SRCB_IMM;
                ctrl_o.alu_command = (opcode_i == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            ST_WB_I: ctrl_o.reg_we = 1'b1;
            // Branch compare issues SUB; zero resolves the PC load in the same cycle.
            ST_BRANCH_EQ, ST_BRANCH_NE: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_command = ALU_SUB;
                ctrl_o.pc_src      = PC_ALUOUT;
                ctrl_o.pc_we       = (state_i == ST_BRANCH_EQ) ? zero_i : ~zero_i;
            end
            ST_JUMP: begin
                ctrl_o.pc_src = PC_JUMP;
                ctrl_o.pc_we  = 1'b1;
            end
            ST_JAL: begin
                ctrl_o.pc_src     = PC_JUMP;
                ctrl_o.pc_we      = 1'b1;
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.reg_dst    = DST_R31;
                ctrl_o.mem_to_reg = M2R_PC;
            end
            ST_JR: begin
                ctrl_o.pc_src = PC_REG_A;
                ctrl_o.pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: state register, next-state logic and sticky
// illegal flag; control outputs come from mc_output_decode.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic               clk,
    input logic               reset,
    mc_control_fsm_if.master  bus
);

    state_e state_q, state_d;
    logic   illegal_q;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= state_e'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == ST_ERROR);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADDR;
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = ST_EXEC_R;
                            FN_JR:                  state_d = ST_JR;
                            default:                state_d = ST_ERROR;
                        endcase
                    end
                    OP_ADDI, OP_XORI: state_d = ST_EXEC_I;
                    OP_BEQ:           state_d = ST_BRANCH_EQ;
                    OP_BNE:           state_d = ST_BRANCH_NE;
                    OP_J:             state_d = ST_JUMP;
                    OP_JAL:           state_d = ST_JAL;
                    default:          state_d = ST_ERROR;
                endcase
            end
            ST_MEMADDR:  state_d = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: state_d = ST_WB_MEM;
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            // ERROR is left only through reset.
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state_i  (state_q),
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .zero_i   (bus.zero),
        .ctrl_o   (ctrl)
    );

    assign bus.alu_command = ctrl.alu_command;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.pc_we       = ctrl.pc_we;
    assign bus.pc_src      = ctrl.pc_src;
    assign bus.ir_we       = ctrl.ir_we;
    assign bus.mem_we      = ctrl.mem_we;
    assign bus.reg_we      = ctrl.reg_we;
    assign bus.reg_dst     = ctrl.reg_dst;
    assign bus.mem_to_reg  = ctrl.mem_to_reg;
    assign bus.illegal     = illegal_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction cycle plans from an instruction-level
// model, checked every cycle against the DUT, with random and directed streams.
module tb_mc_control_fsm;

    localparam int W = 21;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] plan_q[$];

    mc_control_fsm_if bus ();

    mc_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: state, alu, src_a, src_b, pc_we, pc_src, ir_we, mem_we,
    // reg_we, reg_dst, mem_to_reg, illegal.
    function automatic logic [W-1:0] mk(input int st, input int alu, input int sa, input int sb,
                                        input int pw, input int ps, input int iw, input int mw,
                                        input int rw, input int rd, input int mr, input int il);
        return {st[3:0], alu[2:0], sa[0], sb[1:0], pw[0], ps[1:0], iw[0], mw[0],
                rw[0], rd[1:0], mr[1:0], il[0]};
    endfunction

    function automatic logic [W-1:0] fetch_vec();
        return mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [W-1:0] err_vec();
        return mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    // Instruction-level model: the full cycle-by-cycle plan of one instruction.
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int err_n);
        bit is_err;
        is_err = 1'b0;
        plan_q.delete();
        plan_q.push_back(fetch_vec());
        plan_q.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            6'h23: begin
                plan_q.push_back(mk(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                plan_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                plan_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            end
            6'h2B: begin
                plan_q.push_back(mk(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                plan_q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            end
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin
                    plan_q.push_back(mk(6, (fn == 6'h22) ? 1 : (fn == 6'h2A) ? 3 : 0,
                                        1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                    plan_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
                end else if (fn == 6'h08) begin
                    plan_q.push_back(mk(14, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
                end else begin
                    is_err = 1'b1;
                end
            end
            6'h08, 6'h0E: begin
                plan_q.push_back(mk(8, (op == 6'h0E) ? 2 : 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                plan_q.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            6'h04: plan_q.push_back(mk(10, 1, 1, 0, z, 1, 0, 0, 0, 0, 0, 0));
            6'h05: plan_q.push_back(mk(11, 1, 1, 0, !z, 1, 0, 0, 0, 0, 0, 0));
            6'h02: plan_q.push_back(mk(12, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
            6'h03: plan_q.push_back(mk(13, 0, 0, 0, 1, 2, 0, 0, 1, 2, 2, 0));
            default: is_err = 1'b1;
        endcase
        if (is_err) begin
            for (int i = 0; i < err_n; i++) plan_q.push_back(err_vec());
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, got, req);
        end
    endtask

    // Reset asserted for len cycles; the first of them still shows the current state.
    task automatic apply_reset(input logic [W-1:0] cur, input int len);
        reset = 1'b1;
        exp_q.push_back(cur);
        for (int i = 1; i < len; i++) exp_q.push_back(fetch_vec());
        repeat (len) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // driver: one instruction, optionally cut short by a reset after `cut` cycles
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int cut, input int err_n, input int rst_len);
        int n;
        logic ended_err;
        plan_instr(op, fn, z, err_n);
        ended_err = plan_q[plan_q.size() - 1][0];
        n = plan_q.size();
        if (cut > 0 && cut < n) n = cut;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int i = 0; i < n; i++) exp_q.push_back(plan_q[i]);
        repeat (n) @(posedge clk);
        #1;
        if (n < plan_q.size()) apply_reset(plan_q[n], rst_len);
        else if (ended_err) apply_reset(err_vec(), rst_len);
    endtask

    // scoreboard: compare every cycle for which the model has an expectation
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {bus.state, bus.alu_command, bus.alu_src_a, bus.alu_src_b, bus.pc_we,
                     bus.pc_src, bus.ir_we, bus.mem_we, bus.reg_we, bus.reg_dst,
                     bus.mem_to_reg, bus.illegal};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ctrl @%0t actual=%h required=%h (state %0d vs %0d)",
                         $time, got_v, exp_v, got_v[20:17], exp_v[20:17]);
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         pick;
        int         cut;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;

        // Hand-computed latencies and key fields pin the model.
        plan_instr(6'h23, 6'h00, 1'b0, 1);
        chk("model_lw_len", plan_q.size(), 5);
        chk("model_lw_m2r", int'(plan_q[4][2:1]), 1);
        plan_instr(6'h2B, 6'h00, 1'b0, 1);
        chk("model_sw_len", plan_q.size(), 4);
        plan_instr(6'h00, 6'h22, 1'b0, 1);
        chk("model_sub_len", plan_q.size(), 4);
        chk("model_sub_alu", int'(plan_q[2][16:14]), 1);
        plan_instr(6'h04, 6'h00, 1'b1, 1);
        chk("model_beq_len", plan_q.size(), 3);
        chk("model_beq_pcwe", int'(plan_q[2][10]), 1);
        plan_instr(6'h03, 6'h00, 1'b0, 1);
        chk("model_jal_bits", int'(plan_q[2][10:0]), 11'b1_10_0_0_1_10_10_0);
        plan_instr(6'h0E, 6'h00, 1'b0, 1);
        chk("model_xori_alu", int'(plan_q[2][16:14]), 2);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Illegal opcode: 10 cycles of ERROR, then a 2-cycle reset from ERROR.
        run_instr(6'h3F, 6'h00, 1'b0, 0, 10, 2);
        run_instr(6'h00, 6'h22, 1'b0, 0, 1, 1);
        run_instr(6'h23, 6'h05, 1'b1, 0, 1, 1);
        run_instr(6'h2B, 6'h11, 1'b0, 0, 1, 1);
        run_instr(6'h04, 6'h00, 1'b1, 0, 1, 1);
        run_instr(6'h04, 6'h00, 1'b0, 0, 1, 1);
        run_instr(6'h05, 6'h00, 1'b1, 0, 1, 1);
        run_instr(6'h05, 6'h00, 1'b0, 0, 1, 1);
        run_instr(6'h03, 6'h00, 1'b0, 0, 1, 1);
        run_instr(6'h0E, 6'h00, 1'b0, 0, 1, 1);
        run_instr(6'h08, 6'h2A, 1'b0, 0, 1, 1);
        run_instr(6'h00, 6'h20, 1'b0, 0, 1, 1);
        run_instr(6'h00, 6'h2A, 1'b1, 0, 1, 1);
        run_instr(6'h00, 6'h08, 1'b0, 0, 1, 1);
        run_instr(6'h02, 6'h00, 1'b0, 0, 1, 1);
        run_instr(6'h00, 6'h01, 1'b0, 0, 2, 1);
        // LW cut by reset while in MEM_READ.
        run_instr(6'h23, 6'h00, 1'b0, 3, 1, 1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1, 1);

        for (int k = 0; k < 150; k++) begin
            pick = $urandom_range(0, 11);
            fn   = 6'($urandom_range(0, 63));
            z    = 1'($urandom_range(0, 1));
            case (pick)
                0:  op = 6'h23;
                1:  op = 6'h2B;
                2:  begin op = 6'h00; fn = 6'h20; end
                3:  begin op = 6'h00; fn = 6'h22; end
                4:  begin op = 6'h00; fn = 6'h2A; end
                5:  begin op = 6'h00; fn = 6'h08; end
                6:  op = 6'h08;
                7:  op = 6'h0E;
                8:  op = 6'h04;
                9:  op = 6'h05;
                10: op = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
                default: op = 6'($urandom_range(0, 63));
            endcase
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(op, fn, z, cut, $urandom_range(1, 3), $urandom_range(1, 2));
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit: the stage directly upstream of the 32-bit ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the ALU 3-bit command, the datapath mux selects and all write enables.
- Consumes the ALU zero flag to resolve BEQ/BNE.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag, valid in the cycle the compare is issued
- alu_command  out  3  ADD=000 SUB=001 XOR=010 SLT=011 AND=100 NAND=101 NOR=110 OR=111
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  0=register B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- pc_we  out  1  PC write enable
- pc_src  out  2  0=ALU result, 1=ALUOut register, 2=jump target, 3=register A (JR)
- ir_we  out  1  instruction register write enable
- mem_we  out  1  data memory write
- reg_we  out  1  register file write
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC (link)
- illegal  out  1  sticky illegal-instruction flag
- state  out  4  current state, for debug and verification

Behaviour:
- Moore machine: outputs decode from the state register only. Exception: BRANCH_EQ/NE pc_we, which is gated by zero.
- During reset and in the cycle after it deasserts: state=FETCH. Every output not asserted by FETCH is 0, alu_command=ADD and illegal=0.
- Any output not listed for a state is 0; alu_command defaults to ADD.
- Reset asserted in any state, including mid-instruction and ERROR, returns the FSM to FETCH on the next edge and clears illegal.
- FETCH: ir_we=1, alu_src_a=0, alu_src_b=1, ADD, pc_src=0, pc_we=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by opcode:
  - 0x23 LW or 0x2B SW -> MEMADDR
  - 0x00 R-type:
    - funct 0x20 ADD, 0x22 SUB, 0x2A SLT -> EXEC_R
    - funct 0x08 -> JR
    - other funct -> ERROR
  - 0x08 ADDI, 0x0E XORI -> EXEC_I
  - 0x04 -> BRANCH_EQ
  - 0x05 -> BRANCH_NE
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - any other opcode -> ERROR
- MEMADDR: alu_src_a=1, alu_src_b=2, ADD. Next: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ -> WB_MEM.
- MEM_WRITE: mem_we=1 -> FETCH.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, command from funct (0x20 ADD, 0x22 SUB, 0x2A SLT) -> WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, ADD for ADDI, XOR for XORI -> WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH_EQ / BRANCH_NE:
  - alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_we = zero for BEQ, ~zero for BNE.
  - -> FETCH.
- JUMP: pc_src=2, pc_we=1 -> FETCH.
- JAL: pc_src=2, pc_we=1, reg_we=1, reg_dst=2, mem_to_reg=2 -> FETCH. PC still holds PC+4 at this edge.
- JR: pc_src=3, pc_we=1 -> FETCH.
- ERROR: all enables 0, illegal=1. Remains in ERROR until reset.
- Latency in cycles:
  - R-type, ADDI/XORI, SW: 4
  - LW: 5
  - BEQ/BNE, J, JAL, JR: 3
- opcode/funct are sampled only in DECODE and in states that decode funct or opcode. They must be stable from the end of FETCH until the instruction returns to FETCH; IR is written only in FETCH.
- state encodings are fixed, in the order listed, from 0: FETCH, DECODE, MEMADDR, MEM_READ, MEM_WRITE, WB_MEM, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH_EQ, BRANCH_NE, JUMP, JAL, JR, ERROR.

Decomposition:
- Shared package/header holds:
  - ALU command codes
  - opcode and funct constants
  - state encodings
  - alu_src_b, pc_src, reg_dst and mem_to_reg select codes
- The ALU and datapath include the same header.
- One sub-module: mc_output_decode, a combinational state-to-control-vector decoder. It is also the source of alu_command for EXEC_R/EXEC_I.
- The top level keeps the state register and next-state logic.

Test Plan:
- Reset: hold reset 2 cycles in ERROR -> state=0, illegal=0, pc_we=1, ir_we=1 on the first post-reset cycle.
- R-type SUB: opcode=0x00, funct=0x22 -> states 0,1,6,7,0. alu_command=001 in EXEC_R; reg_we=1 with reg_dst=1 only in WB_R.
- LW then SW:
  - opcode 0x23 -> 5-cycle path, mem_to_reg=1 in WB_MEM.
  - opcode 0x2B -> mem_we=1 exactly one cycle, in state 4.
- Branches:
  - BEQ with zero=1 -> pc_we=1, pc_src=1.
  - BEQ with zero=0 -> pc_we=0.
  - BNE inverts both results.
  - Each completes in 3 cycles.
- JAL: opcode 0x03 -> reg_dst=2, mem_to_reg=2, reg_we=1 and pc_we=1 in the same cycle. XORI 0x0E -> alu_command=010 in EXEC_I.
- Illegal: opcode 0x3F -> ERROR, illegal=1, no enables for 10 cycles. Reset mid-LW in MEM_READ -> FETCH next edge.
